// File: rtl/simple_fixed_point_pkg.sv
// Shared constants and FSM state type for the unsigned fixed-point
// shift-and-add multiplier.
package simple_fixed_point_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_FRAC  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to index every multiplier bit (at least one bit).
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fixed_point_round_sat.sv
// Converts the double-width product back to the operand Q format:
// round half up, then clamp to all ones when the integer part overflows.
module fixed_point_round_sat
  import simple_fixed_point_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  localparam int               EXT_W = 2*WIDTH + 1;
  localparam logic [EXT_W-1:0] HALF  = EXT_W'(1) << (FRAC - 1);

  // One spare MSB keeps the rounding carry out of an all-ones product.
  function automatic logic [WIDTH:0] round_sat(input logic [2*WIDTH-1:0] x);
    logic [EXT_W-1:0] r;
    logic             ovf;
    r   = ({1'b0, x} + HALF) >> FRAC;
    ovf = |r[EXT_W-1:WIDTH];
    return {ovf, ovf ? {WIDTH{1'b1}} : r[WIDTH-1:0]};
  endfunction

  always_comb begin
    {overflow, result} = round_sat(acc);
  end

endmodule

// File: rtl/simple_fixed_point_unsigned_long_multiplier.sv
// Sequential unsigned fixed-point multiplier: one multiplier bit per cycle
// into a double-width accumulator, then a registered round/saturate result.
module simple_fixed_point_unsigned_long_multiplier
  import simple_fixed_point_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             overflow
);

  localparam int               ACC_W    = 2*WIDTH;
  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] addend;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q;
  logic             ovf_q;
  logic [WIDTH-1:0] rs_result;
  logic             rs_overflow;
  logic             accept;
  logic             calc_last;

  assign accept    = (state_q == IDLE) && in_valid;
  assign calc_last = (state_q == CALC) && (cnt_q == LAST_BIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (cnt_q == LAST_BIT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Multiplicand aligned to the weight of the multiplier bit under test.
  assign addend = {{WIDTH{1'b0}}, a_q} << cnt_q;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      if (b_q[cnt_q]) begin
        acc_d = acc_q + addend;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Fed from acc_d so the final partial product lands in the DONE result.
  fixed_point_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_round_sat (
    .acc      (acc_d),
    .result   (rs_result),
    .overflow (rs_overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (calc_last) begin
      data_q <= rs_result;
      ovf_q  <= rs_overflow;
    end
  end

  assign data_out = data_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_simple_fixed_point_unsigned_long_multiplier.sv
// Self-checking bench: directed vectors, backpressure, reset abort,
// back-to-back throughput and a randomized regression against a numeric model.
module tb_simple_fixed_point_unsigned_long_multiplier;

  localparam int W       = 8;
  localparam int F       = 4;
  localparam int LAT     = W + 1;
  localparam int N_RAND  = 2000;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  simple_fixed_point_unsigned_long_multiplier #(
    .WIDTH (W),
    .FRAC  (F)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Real-number semantics: product, add half an LSB, drop fraction, clamp.
  function automatic logic [W:0] model(input int unsigned x, input int unsigned y);
    longint unsigned r;
    r = (longint'(x) * longint'(y) + (longint'(1) << (F - 1))) >> F;
    if (r >= (longint'(1) << W)) return {1'b1, {W{1'b1}}};
    return {1'b0, W'(r)};
  endfunction

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit consume,
                        output logic [W-1:0] d, output logic ov, output int lat,
                        output int wait_acc, output bit to);
    to = 1'b0; wait_acc = 0; lat = 0; d = 'x; ov = 1'bx;
    a = ia; b = ib; in_valid = 1'b1;
    while (!in_ready && wait_acc < 50) begin
      @(posedge clk); #1; wait_acc++;
    end
    if (!in_ready) begin
      to = 1'b1; in_valid = 1'b0; return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      to = 1'b1; return;
    end
    d = data_out; ov = overflow;
    if (consume) begin
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || data_out !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got out_valid=%b data_out=%h overflow=%b, required 0/00/0",
               out_valid, data_out, overflow);
    end
    reset = 1'b0; #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{8'h18, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h40, 8'h3F};
    logic [W-1:0] tb [7] = '{8'h20, 8'h08, 8'h07, 8'hFF, 8'hFF, 8'h40, 8'h40};
    logic [W-1:0] td [7] = '{8'h30, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFC};
    logic         to_ [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] d;
    logic         ov;
    int           lat, wa;
    bit           to;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], 1'b1, d, ov, lat, wa, to);
      n_checks++;
      if (to !== 1'b0) begin
        n_fail++; $display("FAIL directed_timeout[%0d]: a=%h b=%h got no result", i, ta[i], tb[i]);
      end
      n_checks++;
      if (d !== td[i] || ov !== to_[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] a=%h b=%h: got data=%h ovf=%b required data=%h ovf=%b",
                 i, ta[i], tb[i], d, ov, td[i], to_[i]);
      end
      n_checks++;
      if (lat != LAT) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    logic         ov;
    int           lat, wa;
    bit           to;
    run_op(8'h18, 8'h20, 1'b0, d, ov, lat, wa, to);
    n_checks++;
    if (to || d !== 8'h30 || ov !== 1'b0) begin
      n_fail++; $display("FAIL bp_result: got data=%h ovf=%b to=%b required 30/0/0", d, ov, to);
    end
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0; in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== 8'h30 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b data=%h ovf=%b required 1/0/30/0",
                 i, out_valid, in_ready, data_out, overflow);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_in_flight();
    logic [W-1:0] d;
    logic         ov;
    int           lat, wa;
    bit           to;
    a = 8'h77; b = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_calc: got out_valid=%b in_ready=%b data=%h ovf=%b required 0/1/00/0",
               out_valid, in_ready, data_out, overflow);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(8'h10, 8'h10, 1'b1, d, ov, lat, wa, to);
    n_checks++;
    if (to || d !== 8'h10 || ov !== 1'b0 || lat != LAT || wa != 0) begin
      n_fail++;
      $display("FAIL reset_recover: got data=%h ovf=%b lat=%0d wait=%0d to=%b required 10/0/%0d/0/0",
               d, ov, lat, wa, to, LAT);
    end
    run_op(8'hA5, 8'h3C, 1'b0, d, ov, lat, wa, to);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || data_out !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got out_valid=%b data=%h ovf=%b required 0/00/0",
               out_valid, data_out, overflow);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq[$];
    logic [W:0] e;
    int         accepts = 0;
    int         last_acc = -1;
    int         cyc = 0;
    int         results = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    a = W'($urandom); b = W'($urandom);
    while ((accepts < 5 || expq.size() > 0) && cyc < 200) begin
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b));
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc > W + 2) begin
            n_fail++; $display("FAIL b2b_period: got %0d cycles required <= %0d", cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        accepts++;
      end
      if (out_valid && out_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : {(W+1){1'bx}};
        results++;
        n_checks++;
        if ({overflow, data_out} !== e) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %h required %h", results, {overflow, data_out}, e);
        end
      end
      @(posedge clk); #1;
      cyc++;
      a = W'($urandom); b = W'($urandom);
      if (accepts >= 5) in_valid = 1'b0;
    end
    n_checks++;
    if (cyc >= 200 || results != 5) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d results in %0d cycles required 5", results, cyc);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic [W:0]   e;
    int           lat;
    bit           busy_bad;
    for (int i = 0; i < N_RAND; i++) begin
      busy_bad = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
      end
      ra = W'($urandom); rb = W'($urandom);
      if (i % 8 == 0) ra = '1;
      if (i % 8 == 1) rb = '0;
      a = ra; b = rb; in_valid = 1'b1;
      e = model(ra, rb);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b required 1", i, in_ready);
      end
      @(posedge clk); #1;
      lat = 1;
      while (!out_valid && lat < 50) begin
        if (in_ready !== 1'b0) busy_bad = 1'b1;
        in_valid = 1'($urandom_range(0, 1)); a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      n_checks++;
      if (lat != LAT) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, LAT);
      end
      n_checks++;
      if ({overflow, data_out} !== e) begin
        n_fail++;
        $display("FAIL rand_data[%0d] a=%h b=%h: got ovf=%b data=%h required ovf=%b data=%h",
                 i, ra, rb, overflow, data_out, e[W], e[W-1:0]);
      end
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'b0; in_valid = 1'($urandom_range(0, 1)); a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || {overflow, data_out} !== e) busy_bad = 1'b1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) busy_bad = 1'b1;
      n_checks++;
      if (busy_bad !== 1'b0) begin
        n_fail++; $display("FAIL rand_handshake[%0d]: got busy/hold violation=%b required 0", i, busy_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_in_flight();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
